// File: rtl/uart_rx_fifo_if.sv
// Receive FIFO bus bundle: receiver strobe/data in, MCU pop/read, status and error flags.
//   slave  : used by uart_rx_fifo (receives rx_*, rd_en, clr_err; drives read data and status)
//   master : used by the agent driving the FIFO (bus bridge / receiver model)
interface uart_rx_fifo_if #(
   parameter int unsigned DEPTH = 16
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          rx_done;
   logic [7:0]    rx_data;
   logic          rd_en;
   logic [7:0]    rd_data;
   logic          rd_valid;
   logic          empty;
   logic          full;
   logic [CW-1:0] count;
   logic          clr_err;
   logic          ovr_err;
   logic          to_flag;
   logic          irq;

   modport slave (
      input  rx_done, rx_data, rd_en, clr_err,
      output rd_data, rd_valid, empty, full, count, ovr_err, to_flag, irq
   );

   modport master (
      output rx_done, rx_data, rd_en, clr_err,
      input  rd_data, rd_valid, empty, full, count, ovr_err, to_flag, irq
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive byte buffer: one push per rising edge of rx_done into a circular FIFO,
// 1-cycle registered pop, sticky overrun, idle-timeout flag and level interrupt.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high; flushes contents and clears all flags
//   bus    : uart_rx_fifo_if.slave (rx_done/rx_data, rd_en/rd_data/rd_valid,
//            empty/full/count, clr_err/ovr_err/to_flag, irq)
module uart_rx_fifo #(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned THRESH      = 8,
   parameter int unsigned TIMEOUT_CYC = 20000
) (
   input  logic          clk,
   input  logic          reset,
   uart_rx_fifo_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic [31:0]   to_cnt;
   logic          rx_done_q;
   logic [7:0]    rd_data_q;
   logic          rd_valid_q;
   logic          ovr_q;
   logic          to_q;

   logic          push_c;
   logic          empty_c;
   logic          full_c;
   logic          do_pop_c;
   logic          do_push_c;
   logic          ovr_c;
   logic          to_hit_c;

   // Event decode from registered state and current inputs
   always_comb begin
      push_c    = bus.rx_done & ~rx_done_q;
      empty_c   = (count_q == '0);
      full_c    = (count_q == CW'(DEPTH));
      do_pop_c  = bus.rd_en & ~empty_c;
      // a same-cycle pop frees a slot, so a push into a full FIFO still lands
      do_push_c = push_c & (~full_c | do_pop_c);
      ovr_c     = push_c & full_c & ~do_pop_c;
      // flag sets on the edge where the idle counter reaches TIMEOUT_CYC
      to_hit_c  = ~empty_c & ~push_c & ~do_pop_c &
                  (to_cnt == 32'(TIMEOUT_CYC) - 32'd1);
   end

   // Storage array; contents need no reset since count gates all reads
   always_ff @(posedge clk) begin
      if (!reset && do_push_c) begin
         mem[wr_ptr] <= bus.rx_data;
      end
   end

   // Pointers, occupancy, read port and edge detector
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         rx_done_q  <= 1'b0;
         rd_data_q  <= 8'h00;
         rd_valid_q <= 1'b0;
      end else begin
         rx_done_q  <= bus.rx_done;
         rd_valid_q <= do_pop_c;
         if (do_push_c) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop_c) begin
            rd_data_q <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + AW'(1);
         end
         case ({do_push_c, do_pop_c})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Idle-timeout counter, saturating at TIMEOUT_CYC
   always_ff @(posedge clk) begin
      if (reset) begin
         to_cnt <= 32'd0;
      end else if (push_c || do_pop_c || empty_c) begin
         to_cnt <= 32'd0;
      end else if (to_cnt != 32'(TIMEOUT_CYC)) begin
         to_cnt <= to_cnt + 32'd1;
      end
   end

   // Sticky overrun (set beats clear) and timeout flag
   always_ff @(posedge clk) begin
      if (reset) begin
         ovr_q <= 1'b0;
         to_q  <= 1'b0;
      end else begin
         if (ovr_c) begin
            ovr_q <= 1'b1;
         end else if (bus.clr_err) begin
            ovr_q <= 1'b0;
         end
         // saturated counter cannot re-trigger, so a cleared flag stays down
         if (do_pop_c || bus.clr_err || empty_c) begin
            to_q <= 1'b0;
         end else if (to_hit_c) begin
            to_q <= 1'b1;
         end
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.count    = count_q;
   assign bus.empty    = empty_c;
   assign bus.full     = full_c;
   assign bus.ovr_err  = ovr_q;
   assign bus.to_flag  = to_q;
   assign bus.irq      = (count_q >= CW'(THRESH)) | ovr_q | to_q;
endmodule
